// File: rtl/uart_rx_byte_if.sv
// Byte-level port bundle between the 8N1 receiver and its host-side user.
// The receiver takes the slave view; whoever drives the serial line takes the master view.
interface uart_rx_byte_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: centre-samples each bit, presents good bytes with a one-cycle
// valid strobe and flags a low stop bit with a one-cycle frame_err strobe instead.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_byte_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [1:0]    r_sync;
    logic          w_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bidx;
    logic [7:0]    r_sh;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          w_cnt_half;
    logic          w_cnt_full;

    assign w_rx_s     = r_sync[1];
    assign w_cnt_half = (r_cnt == CNT_HALF);
    assign w_cnt_full = (r_cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bidx      <= 3'd0;
            r_sh        <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], bus.rx};
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    // A start bit that is no longer low at its centre was a glitch.
                    if (w_cnt_half) begin
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_bidx  <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_full) begin
                        r_sh  <= {w_rx_s, r_sh[7:1]};
                        r_cnt <= '0;
                        if (r_bidx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bidx <= r_bidx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_cnt_full) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_sh;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Hold off until the line idles so a break cannot look like a start bit.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames, with
// expected pulses (byte, kind, arrival cycle) predicted from the frame timing rules.
module tb_uart_rx_byte;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // rx driven low on a falling edge is first sampled on the next rising edge;
    // E0 is two edges later and the pulse follows the stop-bit sample.
    localparam int PULSE_LAT = 3 + HALF + 9 * CPB;

    typedef struct packed {
        logic [7:0]  d;
        logic        err;
        logic [31:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t       exp_q[$];
    exp_t       e_item;
    logic [7:0] hist[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    uart_rx_byte_if bus();

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse monitor: every valid/frame_err must match the oldest predicted pulse.
    always @(negedge clk) begin
        if (rst_q) begin
            exp_q.delete();
            last_good = 8'h00;
        end
        if (bus.valid || bus.frame_err) begin
            check_eq("pulse_exclusive", 32'(bus.valid & bus.frame_err), 32'd0);
            check_eq("pulse_width", 32'(prev_pulse), 32'd0);
            check_eq("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_item = exp_q.pop_front();
                check_eq("pulse_cycle", 32'(cyc), e_item.t);
                check_eq("pulse_kind", 32'(bus.frame_err), 32'(e_item.err));
                if (bus.valid) begin
                    check_eq("valid_data", 32'(bus.data), 32'(e_item.d));
                    check_eq("busy_at_valid", 32'(bus.busy), 32'd0);
                    last_good = e_item.d;
                    hist.push_back(bus.data);
                end else begin
                    check_eq("ferr_data_hold", 32'(bus.data), 32'(last_good));
                    check_eq("busy_at_ferr", 32'(bus.busy), 32'd1);
                end
                $display("[TB] pulse %s data=%02h at cycle %0d", bus.valid ? "valid" : "frame_err",
                         bus.data, cyc);
            end
        end
        prev_pulse = bus.valid | bus.frame_err;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        exp_q.push_back('{d: b, err: ~stop_ok, t: 32'(cyc + PULSE_LAT)});
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop_ok;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] d);
        check_eq({tag, "_data"}, 32'(bus.data), 32'(d));
        check_eq({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check_eq({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [7:0]  rb;
        logic        rok;
        int          gap;

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset", 8'h00);

        for (int i = 0; i < 10; i++) begin
            repeat (50) @(negedge clk);
            check_idle_outputs("idle", 8'h00);
        end

        send_frame(8'hA5, 1'b1);
        check_eq("single_a5", 32'(bus.data), 32'hA5);

        send_frame(8'hDE, 1'b1);
        send_frame(8'hAD, 1'b1);
        send_frame(8'hBE, 1'b1);
        send_frame(8'hEF, 1'b1);
        repeat (4) @(negedge clk);
        word = {hist[hist.size() - 4], hist[hist.size() - 3], hist[hist.size() - 2], hist[hist.size() - 1]};
        check_eq("accum_word", word, 32'hDEADBEEF);

        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("glitch_busy_high", 32'(bus.busy), 32'd1);
        repeat (20) @(negedge clk);
        check_idle_outputs("glitch_after", 8'hEF);

        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check_eq("ferr_busy_hold", 32'(bus.busy), 32'd1);
        check_eq("ferr_data_kept", 32'(bus.data), 32'hEF);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("ferr_recover", 8'hEF);
        send_frame(8'h55, 1'b1);
        check_eq("after_ferr_55", 32'(bus.data), 32'h55);

        repeat (10) @(negedge clk);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.rx = k[0];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = 1'b1;
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midreset", 8'h00);
        repeat (40) @(negedge clk);
        check_idle_outputs("midreset_quiet", 8'h00);
        send_frame(8'h81, 1'b1);
        check_eq("after_reset_81", 32'(bus.data), 32'h81);

        for (int i = 0; i < 24; i++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 4) != 0);
            send_frame(rb, rok);
            if (!rok) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                bus.rx = 1'b1;
                gap = $urandom_range(1, 10);
            end else begin
                gap = $urandom_range(0, 10);
            end
            repeat (gap) @(negedge clk);
        end

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("all_pulses_seen", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous 8N1 serial receiver that recovers bytes from the host link and presents each one with a single-cycle strobe. It sits directly upstream of the byte-wise left-shift word accumulator: `data` drives its byte input and `valid` drives its shift-enable, so four consecutive bytes assemble a 32-bit word with the first byte received in the MSBs. It also reports framing errors and discards bad bytes so they never reach the accumulator.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range ≥ 4.
- `HALF` (localparam) = `CLKS_PER_BIT/2` (integer division).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous active-high reset (only one clock in the block; reset is synchronous and active-high).
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data`  out  8  last correctly framed byte; holds until the next good byte.
- `valid`  out  1  one-cycle pulse: `data` is new this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Two-flop synchronizer on `rx` → `rx_s`; both flops reset to 1. All decisions use `rx_s` only.
- Bit-period counter `cnt`, sized for `CLKS_PER_BIT-1`; bit index `bidx` 0..7; shift register `sh[7:0]`, LSB first (each sample enters `sh[7]`, `sh` shifts right).
- IDLE: `rx_s==0` → START, `cnt←0`.
- START: count up; at `cnt==HALF-1`: `rx_s==0` → DATA (`cnt←0`, `bidx←0`); `rx_s==1` → IDLE (glitch rejected, no pulse).
- DATA: at `cnt==CLKS_PER_BIT-1`: sample `rx_s` into `sh`, `cnt←0`; `bidx==7` → STOP, else `bidx++`.
- STOP: at `cnt==CLKS_PER_BIT-1`: `rx_s==1` → `data←sh`, `valid←1`, IDLE; `rx_s==0` → `frame_err←1`, `data` unchanged, WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s==1`, then IDLE. This prevents a break or stuck-low line from re-triggering.
- `valid` and `frame_err` are mutually exclusive and never high for more than one cycle.
- Reset values: state IDLE, `data=8'h00`, `valid=0`, `frame_err=0`, `busy=0`, `cnt=0`, `bidx=0`, `sh=0`, sync flops = 1.
- `rst` asserted at any point, including mid-frame, returns the block to the reset state on the next edge. The partial byte is lost and no pulse is produced. After reset, a line already low is treated as a new start bit.

## Timing
- Let E0 be the edge on which IDLE first sees `rx_s==0`. This is 2 edges after `rx` first samples low.
- Start check happens at E0+HALF.
- Data bit k is sampled at E0+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit is sampled at E0+HALF+9·CLKS_PER_BIT. `valid`/`frame_err` are high in the cycle after that edge.
- Back-to-back frames: the block returns to IDLE mid-stop-bit. A start edge arriving right after the stop bit is accepted with no lost cycle.
- Baud tolerance: sampling at bit centre tolerates ±4% aggregate clock mismatch over a frame.
- `busy` rises the cycle after E0 and falls the cycle `valid` or `frame_err` is driven. After a framing error, `busy` stays high through WAIT_IDLE.

## Test plan
- Reset then idle: `CLKS_PER_BIT=16`, hold `rx=1` for 500 cycles → `data=00`, `valid`, `frame_err` and `busy` stay 0.
- Single byte: send 0xA5 at the exact bit rate → one `valid` pulse with `data=A5` on the cycle after the stop-bit sample (E0+HALF+144 edges). `frame_err` stays 0.
- Four back-to-back bytes 0xDE, 0xAD, 0xBE, 0xEF, each with a minimal 1-bit stop → four `valid` pulses with those values in order. The downstream accumulator reads 32'hDEADBEEF.
- Glitch: `rx` low for 5 cycles, then high → returns to IDLE at the start check. No pulse; `busy` drops.
- Framing error: send 0x3C with stop bit low, then hold low for 40 cycles → one `frame_err` pulse, `data` keeps its prior value, and `busy` stays high until `rx` returns high. The next valid byte 0x55 is then received correctly.
- Reset mid-frame: assert `rst` for 1 cycle during data bit 4 → all outputs return to reset values and no pulse is produced. A following frame 0x81 is received correctly.
